// File: rtl/bit_rev_stream_pkg.sv
// rtl/bit_rev_stream_pkg.sv - shared constants, state type and slot helper for the chunked bit reverser
package bit_rev_stream_pkg;

    // Word geometry: the full word is carried as NBEATS beats of CHUNK bits.
    localparam int NBITS  = 100;
    localparam int CHUNK  = 25;
    localparam int NBEATS = NBITS / CHUNK;

    // Beat counter width and the index of the final beat of a word.
    localparam int                CNT_W     = $clog2(NBEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

    // FILL collects input beats, DRAIN emits the reversed word.
    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // Input beat k lands reversed in slot NBEATS-1-k, so the drain side can
    // read slot k directly as output beat k.
    function automatic logic [CNT_W-1:0] store_slot(input logic [CNT_W-1:0] beat);
        return LAST_BEAT - beat;
    endfunction

endpackage

// File: rtl/chunk_bit_rev.sv
// rtl/chunk_bit_rev.sv - combinational bit reverser for one chunk
module chunk_bit_rev
    import bit_rev_stream_pkg::*;
#(
    parameter int W = CHUNK
) (
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data
);

    // Pure wiring: output bit i is input bit W-1-i.
    for (genvar gi = 0; gi < W; gi++) begin : g_rev
        assign o_data[gi] = i_data[W-1-gi];
    end

endmodule

// File: rtl/bit_rev_stream_chunked.sv
// rtl/bit_rev_stream_chunked.sv - buffers a 100-bit word in 25-bit beats and streams out its bit-reverse
module bit_rev_stream_chunked
    import bit_rev_stream_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [CHUNK-1:0] in_msg,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [CHUNK-1:0] out_msg,
    output logic             out_last
);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CHUNK-1:0] r_buf [NBEATS];

    logic [CHUNK-1:0] w_rev_chunk;
    logic [CNT_W-1:0] w_slot;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_cnt_last;

    // Each chunk is reversed on its way into the buffer.
    chunk_bit_rev #(
        .W (CHUNK)
    ) u_chunk_bit_rev (
        .i_data (in_msg),
        .o_data (w_rev_chunk)
    );

    assign w_slot     = store_slot(r_cnt);
    assign w_in_fire  = in_val && in_rdy;
    assign w_out_fire = out_val && out_rdy;
    assign w_cnt_last = (r_cnt == LAST_BEAT);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: leave a phase only on the transfer of its last beat.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FILL: begin
                if (w_in_fire && w_cnt_last) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_out_fire && w_cnt_last) begin
                    w_state_next = FILL;
                end
            end
            default: w_state_next = FILL;
        endcase
    end

    // Outputs: handshakes follow the phase; out_msg is forced to 0 outside DRAIN.
    always_comb begin
        in_rdy   = 1'b0;
        out_val  = 1'b0;
        out_msg  = '0;
        out_last = 1'b0;
        case (r_state)
            FILL: begin
                in_rdy = 1'b1;
            end
            DRAIN: begin
                out_val  = 1'b1;
                out_msg  = r_buf[r_cnt];
                out_last = w_cnt_last;
            end
            default: begin
                in_rdy = 1'b0;
            end
        endcase
    end

    // Beat counter: steps on each transfer of the active side, wraps after the last beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_in_fire || w_out_fire) begin
            if (w_cnt_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Word buffer: store the reversed chunk in its mirrored slot on each input transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NBEATS; i++) begin
                r_buf[i] <= '0;
            end
        end else if (w_in_fire) begin
            r_buf[w_slot] <= w_rev_chunk;
        end
    end

endmodule

// File: tb/tb_bit_rev_stream_chunked.sv
// tb/tb_bit_rev_stream_chunked.sv - directed and randomised checks of the chunked bit reverser
module tb_bit_rev_stream_chunked;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_val;
    logic        in_rdy;
    logic [24:0] in_msg;
    logic        out_val;
    logic        out_rdy;
    logic [24:0] out_msg;
    logic        out_last;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bit_rev_stream_chunked dut (
        .clk      (clk),
        .reset    (reset),
        .in_val   (in_val),
        .in_rdy   (in_rdy),
        .in_msg   (in_msg),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .out_msg  (out_msg),
        .out_last (out_last)
    );

    function automatic logic [99:0] rev100(input logic [99:0] w);
        logic [99:0] r;
        for (int i = 0; i < 100; i++) r[i] = w[99-i];
        return r;
    endfunction

    task automatic check(input string tag, input logic [99:0] got, input logic [99:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_word(input logic [99:0] w, input int max_gap);
        int   n;
        logic to;
        for (int k = 0; k < 4; k++) begin
            if (max_gap > 0) begin
                int g;
                g = $urandom_range(max_gap, 0);
                repeat (g) begin
                    in_val = 1'b0;
                    in_msg = 25'($urandom);
                    @(posedge clk); #1;
                end
            end
            in_val = 1'b1;
            in_msg = w[25*k +: 25];
            to = 1'b0;
            n  = 0;
            @(negedge clk);
            while (!in_rdy && !to) begin
                n++;
                if (n > 200) to = 1'b1;
                else @(negedge clk);
            end
            if (to) check("in_timeout", 100'(to), 100'(0));
            @(posedge clk); #1;
        end
        in_val = 1'b0;
        in_msg = 25'($urandom);
    endtask

    task automatic recv_word(output logic [99:0] got, output logic [3:0] lasts, input int max_gap);
        int   n;
        logic to;
        got   = '0;
        lasts = '0;
        for (int k = 0; k < 4; k++) begin
            if (max_gap > 0) begin
                int g;
                g = $urandom_range(max_gap, 0);
                repeat (g) begin
                    out_rdy = 1'b0;
                    @(posedge clk); #1;
                end
            end
            out_rdy = 1'b1;
            to = 1'b0;
            n  = 0;
            @(negedge clk);
            while (!out_val && !to) begin
                n++;
                if (n > 200) to = 1'b1;
                else @(negedge clk);
            end
            if (to) check("out_timeout", 100'(to), 100'(0));
            got[25*k +: 25] = out_msg;
            lasts[k]        = out_last;
            @(posedge clk); #1;
        end
        out_rdy = 1'b0;
    endtask

    task automatic xfer(input logic [99:0] w, input int max_gap,
                        output logic [99:0] got, output logic [3:0] lasts);
        fork
            send_word(w, max_gap);
            recv_word(got, lasts, max_gap);
        join
    endtask

    logic [99:0]  got;
    logic [3:0]   lasts;
    logic [99:0]  w_in;
    logic [99:0]  w_exp;
    logic [127:0] r128;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset   = 1'b1;
        in_val  = 1'b0;
        in_msg  = '0;
        out_rdy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_rdy",   100'(in_rdy),   100'(1));
        check("rst_out_val",  100'(out_val),  100'(0));
        check("rst_out_last", 100'(out_last), 100'(0));
        check("rst_out_msg",  100'(out_msg),  100'(0));
        @(posedge clk); #1;
        reset = 1'b0;

        // Single low bit moves to the top of the last output beat.
        xfer(100'h1, 0, got, lasts);
        check("t1_beat0", 100'(got[24:0]),  100'(0));
        check("t1_beat1", 100'(got[49:25]), 100'(0));
        check("t1_beat2", 100'(got[74:50]), 100'(0));
        check("t1_beat3", 100'(got[99:75]), 100'(25'h1000000));
        check("t1_last",  100'(lasts),      100'(4'b1000));

        // Single top bit moves to bit 0 of the first output beat.
        xfer(100'h8000000000000000000000000, 0, got, lasts);
        check("t2_beat0", 100'(got[24:0]),  100'(25'h1));
        check("t2_beat1", 100'(got[49:25]), 100'(0));
        check("t2_beat3", 100'(got[99:75]), 100'(0));

        // Two all-ones words at full rate: 4 cycles fill, 4 cycles drain.
        in_val  = 1'b1;
        in_msg  = 25'h1FFFFFF;
        out_rdy = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            check($sformatf("tp_in_rdy_%0d", c),   100'(in_rdy),   100'((c % 8) < 4));
            check($sformatf("tp_out_val_%0d", c),  100'(out_val),  100'((c % 8) >= 4));
            check($sformatf("tp_out_last_%0d", c), 100'(out_last), 100'((c % 8) == 7));
            if ((c % 8) >= 4) check($sformatf("tp_msg_%0d", c), 100'(out_msg), 100'(25'h1FFFFFF));
            @(posedge clk); #1;
        end
        in_val  = 1'b0;
        out_rdy = 1'b0;

        // Backpressure at drain beat 1 while in_val is also asserted.
        w_in  = 100'h8deadbeefdeadbeefdeadbeef;
        w_exp = 100'hf77db57bf77db57bf77db57b1;
        send_word(w_in, 0);
        out_rdy = 1'b1;
        @(negedge clk);
        check("bp_beat0_val", 100'(out_val), 100'(1));
        got = '0;
        got[24:0] = out_msg;
        @(posedge clk); #1;
        out_rdy = 1'b0;
        in_val  = 1'b1;
        in_msg  = 25'h0123456;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("bp_hold_msg_%0d", c),  100'(out_msg),  100'(w_exp[49:25]));
            check($sformatf("bp_hold_last_%0d", c), 100'(out_last), 100'(0));
            check($sformatf("bp_in_rdy_%0d", c),    100'(in_rdy),   100'(0));
            @(posedge clk); #1;
            in_msg = 25'($urandom);
        end
        in_val = 1'b0;
        for (int k = 1; k < 4; k++) begin
            out_rdy = 1'b1;
            @(negedge clk);
            got[25*k +: 25] = out_msg;
            check($sformatf("bp_last_%0d", k), 100'(out_last), 100'(k == 3));
            @(posedge clk); #1;
        end
        out_rdy = 1'b0;
        check("bp_word", got, w_exp);

        // Reset after two input beats discards the partial word.
        in_val = 1'b1;
        in_msg = 25'h1555555;
        @(posedge clk); #1;
        in_msg = 25'h0ABCDEF;
        @(posedge clk); #1;
        in_val = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rf_async_in_rdy",  100'(in_rdy),  100'(1));
        check("rf_async_out_val", 100'(out_val), 100'(0));
        @(negedge clk);
        check("rf_hold_out_val", 100'(out_val), 100'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rf_after_in_rdy",  100'(in_rdy),  100'(1));
        check("rf_after_out_val", 100'(out_val), 100'(0));
        @(posedge clk); #1;
        xfer(100'h189abcdef89abcdef89abcdef, 0, got, lasts);
        check("rf_word", got, 100'hf7b3d591f7b3d591f7b3d5918);
        check("rf_last", 100'(lasts), 100'(4'b1000));

        // Reset in the middle of DRAIN drops the outputs immediately.
        send_word(100'h123456789abcdef0123456789, 0);
        @(negedge clk);
        check("rd_pre_out_val", 100'(out_val), 100'(1));
        #2 reset = 1'b1;
        #1;
        check("rd_async_out_val",  100'(out_val),  100'(0));
        check("rd_async_out_msg",  100'(out_msg),  100'(0));
        check("rd_async_in_rdy",   100'(in_rdy),   100'(1));
        @(posedge clk); #1;
        reset = 1'b0;
        xfer(100'h1, 0, got, lasts);
        check("rd_next_word", got, 100'h8000000000000000000000000);

        // Random words with random gaps on both sides.
        for (int t = 0; t < 20; t++) begin
            r128 = {$urandom, $urandom, $urandom, $urandom};
            w_in = r128[99:0];
            xfer(w_in, 3, got, lasts);
            check($sformatf("rnd_word_%0d", t), got, rev100(w_in));
            check($sformatf("rnd_last_%0d", t), 100'(lasts), 100'(4'b1000));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
